// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader: FSM state encoding,
// default bit timing, and the address helper used for instruction-memory writes.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_OK     = 3'd4,
    ST_ERR    = 3'd5
  } loader_state_t;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 5208;
  // Roughly four byte-times of silence before a frame is abandoned.
  localparam int unsigned DEFAULT_TIMEOUT_CLKS = 40 * DEFAULT_CLKS_PER_BIT;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/uart_loader_word_assembler.sv
// Packs little-endian bytes into 32-bit words; word_valid pulses for one cycle
// after the fourth byte of a word has been taken.
module uart_loader_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        lane_last,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  k_reg;
  logic [23:0] shift_reg;
  logic [31:0] word_reg;
  logic        word_valid_reg;

  assign lane_last  = (k_reg == 2'd3);
  assign word       = word_reg;
  assign word_valid = word_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg          <= 2'd0;
      shift_reg      <= 24'd0;
      word_reg       <= 32'd0;
      word_valid_reg <= 1'b0;
    end else begin
      word_valid_reg <= 1'b0;
      if (clear) begin
        k_reg     <= 2'd0;
        shift_reg <= 24'd0;
      end else if (byte_en) begin
        k_reg <= k_reg + 2'd1;
        case (k_reg)
          2'd0:    shift_reg[7:0]   <= byte_in;
          2'd1:    shift_reg[15:8]  <= byte_in;
          2'd2:    shift_reg[23:16] <= byte_in;
          default: begin
            word_reg       <= {byte_in, shift_reg};
            word_valid_reg <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Frame-level loader: length, data words and XOR checksum from the UART byte
// stream; writes words to instruction memory and releases the CPU on success.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned MAX_WORDS    = 1024,
  parameter int unsigned TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_DONE,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic        LOAD_DONE,
  output logic        LOAD_ERR,
  output logic        CPU_HOLD
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  loader_state_t    state_reg, state_next;
  logic [15:0]      n_reg, n_next;
  logic [7:0]       chk_reg, chk_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [31:0]      addr_reg, addr_next;
  logic [31:0]      tmr_reg, tmr_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic             hold_reg, hold_next;

  logic             asm_clear, asm_en, asm_lane_last, asm_valid;
  logic [31:0]      asm_word;
  logic [15:0]      n_full;
  logic [IDX_W-1:0] idx_inc;

  assign n_full  = {RX_DATA, n_reg[7:0]};
  assign idx_inc = idx_reg + IDX_W'(1);

  uart_loader_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_en    (asm_en),
    .byte_in    (RX_DATA),
    .lane_last  (asm_lane_last),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  assign MEM_WE    = asm_valid;
  assign MEM_WDATA = asm_word;
  assign MEM_ADDR  = addr_reg;
  assign LOAD_DONE = done_reg;
  assign LOAD_ERR  = err_reg;
  assign CPU_HOLD  = hold_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      n_reg     <= 16'd0;
      chk_reg   <= 8'd0;
      idx_reg   <= '0;
      addr_reg  <= BASE_ADDR;
      tmr_reg   <= 32'd0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      hold_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      chk_reg   <= chk_next;
      idx_reg   <= idx_next;
      addr_reg  <= addr_next;
      tmr_reg   <= tmr_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      hold_reg  <= hold_next;
    end
  end

  // Completion flags are set on the transition itself so they appear one clock
  // after the deciding byte; OK/ERR only spend a cycle before returning to IDLE.
  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    chk_next   = chk_reg;
    idx_next   = idx_reg;
    addr_next  = addr_reg;
    tmr_next   = 32'd0;
    done_next  = done_reg;
    err_next   = err_reg;
    hold_next  = hold_reg;
    asm_clear  = 1'b0;
    asm_en     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (RX_DONE) begin
          n_next     = {8'd0, RX_DATA};
          chk_next   = RX_DATA;
          idx_next   = '0;
          done_next  = 1'b0;
          err_next   = 1'b0;
          hold_next  = 1'b1;
          asm_clear  = 1'b1;
          state_next = ST_LEN_HI;
        end
      end
      ST_LEN_HI, ST_DATA, ST_CSUM: begin
        if (RX_DONE) begin
          chk_next = chk_reg ^ RX_DATA;
          if (state_reg == ST_LEN_HI) begin
            n_next = n_full;
            if (32'(n_full) > MAX_WORDS) begin
              err_next   = 1'b1;
              state_next = ST_ERR;
            end else if (n_full == 16'd0) begin
              state_next = ST_CSUM;
            end else begin
              state_next = ST_DATA;
            end
          end else if (state_reg == ST_DATA) begin
            asm_en = 1'b1;
            if (asm_lane_last) begin
              addr_next = word_addr(BASE_ADDR, 32'(idx_reg));
              idx_next  = idx_inc;
              if (16'(idx_inc) == n_reg)
                state_next = ST_CSUM;
            end
          end else if (RX_DATA == chk_reg) begin
            done_next  = 1'b1;
            hold_next  = 1'b0;
            state_next = ST_OK;
          end else begin
            err_next   = 1'b1;
            state_next = ST_ERR;
          end
        end else if (tmr_reg == TIMEOUT_CLKS - 1) begin
          err_next   = 1'b1;
          asm_clear  = 1'b1;
          state_next = ST_ERR;
        end else begin
          tmr_next = tmr_reg + 32'd1;
        end
      end
      ST_OK, ST_ERR: state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_loader.sv
// Randomized frame-level bench for uart_loader: a scoreboard queue of expected
// memory writes and completion events, popped by an independent monitor.
module tb_uart_loader;

  localparam int          T    = 300;
  localparam int          MAXW = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_DONE = 1'b0;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic        LOAD_DONE;
  logic        LOAD_ERR;
  logic        CPU_HOLD;

  uart_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT_CLKS(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX_DATA   (RX_DATA),
    .RX_DONE   (RX_DONE),
    .MEM_WE    (MEM_WE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .LOAD_DONE (LOAD_DONE),
    .LOAD_ERR  (LOAD_ERR),
    .CPU_HOLD  (CPU_HOLD)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; logic [31:0] data; int unsigned at; } wr_t;
  typedef struct { logic done; logic err; logic hold; int unsigned at; } st_t;

  wr_t         wr_q[$];
  st_t         st_q[$];
  logic [31:0] preset[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned last_vis = 0;
  logic        prev_out = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write and every completion event must match the queue head.
  always @(negedge clk) begin
    wr_t w;
    st_t s;
    if (!rst) begin
      if (MEM_WE) begin
        check("write_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          check("wr_addr", MEM_ADDR, w.addr);
          check("wr_data", MEM_WDATA, w.data);
          check("wr_cycle", cyc, w.at);
          $display("write addr=0x%08h data=0x%08h cycle=%0d", MEM_ADDR, MEM_WDATA, cyc);
        end
      end
      if ((LOAD_DONE | LOAD_ERR) && !prev_out) begin
        check("status_expected", 32'(st_q.size() != 0), 32'd1);
        if (st_q.size() != 0) begin
          s = st_q.pop_front();
          check("load_done", 32'(LOAD_DONE), 32'(s.done));
          check("load_err", 32'(LOAD_ERR), 32'(s.err));
          check("cpu_hold", 32'(CPU_HOLD), 32'(s.hold));
          check("status_cycle", cyc, s.at);
          $display("status done=%0d err=%0d hold=%0d cycle=%0d", LOAD_DONE, LOAD_ERR, CPU_HOLD, cyc);
        end
      end
    end
    prev_out = LOAD_DONE | LOAD_ERR;
  end

  // Called at a falling edge; the byte is sampled on the next rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    RX_DATA  = b;
    RX_DONE  = 1'b1;
    last_vis = cyc + 1;
    @(negedge clk);
    RX_DONE = 1'b0;
    RX_DATA = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  // Reference model: build the frame byte list from N and the words, predict each
  // write (word i at BASE+4i) and the final outcome, then drive the bytes.
  task automatic send_frame(input int n, input logic bad, input int abort_at,
                            input int maxgap, input int long_at, input logic do_rst);
    logic [7:0]  bytes[$];
    logic [31:0] words[$];
    logic [31:0] w;
    logic [7:0]  x, b;
    int          total, g, di;
    logic [15:0] n16;
    n16 = 16'(n);
    bytes.push_back(n16[7:0]);
    bytes.push_back(n16[15:8]);
    if (n <= MAXW) begin
      for (int i = 0; i < n; i++) begin
        w = (i < preset.size()) ? preset[i] : $urandom;
        words.push_back(w);
        for (int k = 0; k < 4; k++) bytes.push_back(w[8*k +: 8]);
      end
    end
    x = 8'h00;
    foreach (bytes[i]) x ^= bytes[i];
    if (bad) x ^= 8'h01;
    if (n > MAXW)           total = 2;
    else if (abort_at >= 0) total = abort_at;
    else                    total = bytes.size() + 1;

    for (int j = 0; j < total; j++) begin
      b  = (j < bytes.size()) ? bytes[j] : x;
      di = j - 2;
      if (n > MAXW && j == 1)
        st_q.push_back('{done: 1'b0, err: 1'b1, hold: 1'b1, at: cyc + 1});
      if (n <= MAXW && di >= 0 && di < 4 * n && (di % 4) == 3)
        wr_q.push_back('{addr: BASE + 32'(4 * (di / 4)), data: words[di / 4], at: cyc + 1});
      if (j == bytes.size())
        st_q.push_back('{done: !bad, err: bad, hold: bad, at: cyc + 1});
      g = (j == long_at) ? T - 1 : $urandom_range(0, maxgap);
      send_byte(b, g);
      if (j == 0) begin
        check("start_hold", 32'(CPU_HOLD), 32'd1);
        check("start_done_clr", 32'(LOAD_DONE), 32'd0);
        check("start_err_clr", 32'(LOAD_ERR), 32'd0);
      end
    end

    if (do_rst) begin
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mem_we", 32'(MEM_WE), 32'd0);
      check("rst_mem_addr", MEM_ADDR, BASE);
      check("rst_mem_wdata", MEM_WDATA, 32'd0);
      check("rst_load_done", 32'(LOAD_DONE), 32'd0);
      check("rst_load_err", 32'(LOAD_ERR), 32'd0);
      check("rst_cpu_hold", 32'(CPU_HOLD), 32'd1);
      rst = 1'b0;
    end else if (abort_at >= 0 && n <= MAXW) begin
      st_q.push_back('{done: 1'b0, err: 1'b1, hold: 1'b1, at: last_vis + T});
      repeat (T + 4) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    preset.delete();
    $display("frame n=%0d bad=%0d abort=%0d rst=%0d done", n, bad, abort_at, do_rst);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_mem_we", 32'(MEM_WE), 32'd0);
    check("reset_mem_addr", MEM_ADDR, BASE);
    check("reset_mem_wdata", MEM_WDATA, 32'd0);
    check("reset_load_done", 32'(LOAD_DONE), 32'd0);
    check("reset_load_err", 32'(LOAD_ERR), 32'd0);
    check("reset_cpu_hold", 32'(CPU_HOLD), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    preset = '{32'h1122_3344, 32'hDEAD_BEEF};
    send_frame(2, 1'b0, -1, 2, -1, 1'b0);
    preset = '{32'h1122_3344, 32'hDEAD_BEEF};
    send_frame(2, 1'b1, -1, 2, -1, 1'b0);
    send_frame(1025, 1'b0, -1, 2, -1, 1'b0);
    send_frame(2, 1'b0, 4, 2, -1, 1'b0);
    send_frame(2, 1'b0, -1, 1, -1, 1'b0);
    send_frame(0, 1'b0, -1, 2, -1, 1'b0);
    send_frame(3, 1'b0, 7, 1, -1, 1'b1);
    send_frame(2, 1'b0, -1, 1, -1, 1'b0);
    send_frame(2, 1'b0, -1, 1, 3, 1'b0);
    send_frame(1, 1'b0, 1, 1, -1, 1'b0);
    for (int r = 0; r < 12; r++)
      send_frame($urandom_range(0, 6), ($urandom_range(0, 3) == 0), -1, 3, -1, 1'b0);
    send_frame(MAXW, 1'b0, -1, 0, -1, 1'b0);
    send_frame(1, 1'b0, -1, 0, -1, 1'b0);

    repeat (5) @(negedge clk);
    check("writes_drained", 32'(wr_q.size()), 32'd0);
    check("status_drained", 32'(st_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
